// File: rtl/instr_decode.sv
// Program sequencer between the instruction store and ctrl_unit: fetches, decodes
// and executes a 4096-word program, issuing commands and register writes to ctrl_unit.
module instr_decode #(
  parameter int PC_W   = 12,
  parameter int DATA_W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              instr_rd_en,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [31:0]       instr_data,
  input  logic              cmd_rdy,
  input  logic              cmd_done,
  output logic              begin_rdn_load,
  output logic              begin_dnn_load,
  output logic              begin_proc,
  output logic [1:0]        reg_sel,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_databus,
  output logic              halted,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_ISSUE,
    S_WAIT_DONE,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP           = 4'h0,
    OP_HALT          = 4'h1,
    OP_SET_IMG_ADDR  = 4'h2,
    OP_SET_IMG_CNT   = 4'h3,
    OP_SET_RSLT_ADDR = 4'h4,
    OP_LOAD_RDN      = 4'h5,
    OP_LOAD_DNN      = 4'h6,
    OP_PROC          = 4'h7,
    OP_JMP           = 4'h8
  } opcode_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [31:0]     r_ir;
  logic            r_halted;
  logic            r_error;
  logic            w_set_halted;
  logic            w_set_error;
  logic            w_clr_flags;
  logic [3:0]      w_opcode;
  logic [PC_W-1:0] w_pc_inc;

  assign w_opcode = r_ir[31:28];
  // Wraps naturally modulo 2^PC_W.
  assign w_pc_inc = r_pc + PC_W'(1);

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_next_state   = r_state;
    w_pc_next      = r_pc;
    w_set_halted   = 1'b0;
    w_set_error    = 1'b0;
    w_clr_flags    = 1'b0;
    instr_rd_en    = 1'b0;
    begin_rdn_load = 1'b0;
    begin_dnn_load = 1'b0;
    begin_proc     = 1'b0;
    reg_sel        = 2'b00;
    reg_wr_en      = 1'b0;
    reg_databus    = '0;

    unique case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        instr_rd_en  = 1'b1;
        w_next_state = S_LATCH;
      end
      S_LATCH: begin
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        w_next_state = S_FETCH;
        case (w_opcode)
          OP_NOP: w_pc_next = w_pc_inc;
          OP_HALT: begin
            w_set_halted = 1'b1;
            w_next_state = S_HALT;
          end
          OP_SET_IMG_ADDR, OP_SET_IMG_CNT, OP_SET_RSLT_ADDR: begin
            reg_wr_en   = 1'b1;
            reg_sel     = w_opcode[1:0] - 2'd2;
            reg_databus = r_ir[DATA_W-1:0];
            w_pc_next   = w_pc_inc;
          end
          OP_LOAD_RDN, OP_LOAD_DNN, OP_PROC: w_next_state = S_ISSUE;
          OP_JMP: w_pc_next = r_ir[PC_W-1:0];
          default: begin
            w_set_error  = 1'b1;
            w_next_state = S_HALT;
          end
        endcase
      end
      S_ISSUE: begin
        // cmd_done is not looked at here, so one coincident with the pulse is dropped.
        if (cmd_rdy) begin
          begin_rdn_load = (w_opcode == OP_LOAD_RDN);
          begin_dnn_load = (w_opcode == OP_LOAD_DNN);
          begin_proc     = (w_opcode == OP_PROC);
          w_next_state   = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (cmd_done) begin
          w_pc_next    = w_pc_inc;
          w_next_state = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          w_clr_flags  = 1'b1;
          w_pc_next    = '0;
          w_next_state = S_FETCH;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_halted <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (r_state == S_LATCH) r_ir <= instr_data;
      if (w_clr_flags) begin
        r_halted <= 1'b0;
        r_error  <= 1'b0;
      end else begin
        if (w_set_halted) r_halted <= 1'b1;
        if (w_set_error)  r_error  <= 1'b1;
      end
    end
  end

  assign instr_addr = r_pc;
  assign halted     = r_halted;
  assign error      = r_error;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: single-instruction decode table plus hand-written
// sequences for command stalls, JMP wrap, spurious cmd_done and mid-command reset.
module tb_instr_decode;

  localparam logic [31:0] HALT_I = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        instr_rd_en;
  logic [11:0] instr_addr;
  logic [31:0] instr_data;
  logic        cmd_rdy;
  logic        cmd_done;
  logic        begin_rdn_load;
  logic        begin_dnn_load;
  logic        begin_proc;
  logic [1:0]  reg_sel;
  logic        reg_wr_en;
  logic [27:0] reg_databus;
  logic        halted;
  logic        error;

  logic [31:0] mem [4096];
  int n_checks = 0;
  int n_fail   = 0;

  instr_decode dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .instr_rd_en    (instr_rd_en),
    .instr_addr     (instr_addr),
    .instr_data     (instr_data),
    .cmd_rdy        (cmd_rdy),
    .cmd_done       (cmd_done),
    .begin_rdn_load (begin_rdn_load),
    .begin_dnn_load (begin_dnn_load),
    .begin_proc     (begin_proc),
    .reg_sel        (reg_sel),
    .reg_wr_en      (reg_wr_en),
    .reg_databus    (reg_databus),
    .halted         (halted),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Instruction store: read data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (instr_rd_en) instr_data <= mem[instr_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("one_strobe", 64'($countones({begin_rdn_load, begin_dnn_load, begin_proc, reg_wr_en})) <= 64'd1, 64'd1);
      if (!reg_wr_en) check("databus_idle_zero", 64'(reg_databus), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    cmd_rdy  = 1'b0;
    cmd_done = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({instr_rd_en, instr_addr, begin_rdn_load, begin_dnn_load, begin_proc,
                reg_sel, reg_wr_en, reg_databus, halted, error});
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        exp_wr;
    logic [1:0]  exp_sel;
    logic [27:0] exp_data;
    logic        exp_rd;
    logic [11:0] exp_addr;
    logic        exp_halted;
    logic        exp_error;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h2000_1234, 1'b1, 2'b00, 28'h000_1234, 1'b1, 12'd1, 1'b1, 1'b0};
    vecs[1] = '{32'h3ABC_DEF0, 1'b1, 2'b01, 28'hABC_DEF0, 1'b1, 12'd1, 1'b1, 1'b0};
    vecs[2] = '{32'h4FFF_FFFF, 1'b1, 2'b10, 28'hFFF_FFFF, 1'b1, 12'd1, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0000, 1'b0, 2'b00, 28'h0,        1'b1, 12'd1, 1'b1, 1'b0};
    vecs[4] = '{32'h8ABC_D005, 1'b0, 2'b00, 28'h0,        1'b1, 12'd5, 1'b1, 1'b0};
    vecs[5] = '{32'h1000_0000, 1'b0, 2'b00, 28'h0,        1'b0, 12'd0, 1'b1, 1'b0};
    vecs[6] = '{32'hA000_0000, 1'b0, 2'b00, 28'h0,        1'b0, 12'd0, 1'b0, 1'b1};
    vecs[7] = '{32'hF123_4567, 1'b0, 2'b00, 28'h0,        1'b0, 12'd0, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; cmd_rdy = 1'b0; cmd_done = 1'b0;
    clear_mem();
    #12;
    check("reset_outputs", all_outs(), 64'd0);

    // Single-instruction programs followed by HALT.
    for (int i = 0; i < 8; i++) begin
      int n;
      clear_mem();
      mem[0] = vecs[i].instr;
      mem[1] = HALT_I;
      mem[5] = HALT_I;
      apply_reset();
      tick();
      check("idle_no_fetch", 64'(instr_rd_en), 64'd0);
      do_start();
      check("fetch_rd_en", 64'(instr_rd_en), 64'd1);
      check("fetch_addr", 64'(instr_addr), 64'd0);
      tick();
      tick();
      check("exec_wr_en", 64'(reg_wr_en), 64'(vecs[i].exp_wr));
      check("exec_sel", 64'(reg_sel), 64'(vecs[i].exp_sel));
      check("exec_data", 64'(reg_databus), 64'(vecs[i].exp_data));
      tick();
      check("next_rd_en", 64'(instr_rd_en), 64'(vecs[i].exp_rd));
      check("next_addr", 64'(instr_addr), 64'(vecs[i].exp_addr));
      n = 0;
      while (!(halted || error) && n < 12) begin
        tick();
        n++;
      end
      check("final_halted", 64'(halted), 64'(vecs[i].exp_halted));
      check("final_error", 64'(error), 64'(vecs[i].exp_error));
    end

    // PROC stalls on cmd_rdy, then waits for cmd_done before fetching addr 1.
    clear_mem();
    mem[0] = 32'h7000_0000;
    mem[1] = HALT_I;
    apply_reset();
    do_start();
    tick();
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check("proc_stall_no_pulse", 64'(begin_proc), 64'd0);
      if (c < 4) tick();
    end
    cmd_rdy = 1'b1;
    #1;
    check("proc_pulse", 64'({begin_rdn_load, begin_dnn_load, begin_proc}), 64'b001);
    tick();
    cmd_rdy = 1'b0;
    check("proc_pulse_once", 64'(begin_proc), 64'd0);
    repeat (10) tick();
    check("proc_wait_no_fetch", 64'(instr_rd_en), 64'd0);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check("proc_next_rd_en", 64'(instr_rd_en), 64'd1);
    check("proc_next_addr", 64'(instr_addr), 64'd1);

    // JMP to 4095, NOP there wraps the PC back to 0.
    clear_mem();
    mem[0] = 32'h8000_0FFF;
    apply_reset();
    do_start();
    check("wrap_addr0", 64'(instr_addr), 64'd0);
    repeat (3) tick();
    check("wrap_rd_4095", 64'(instr_rd_en), 64'd1);
    check("wrap_addr4095", 64'(instr_addr), 64'd4095);
    repeat (3) tick();
    check("wrap_rd_0", 64'(instr_rd_en), 64'd1);
    check("wrap_addr0_again", 64'(instr_addr), 64'd0);

    // Illegal opcode, then start from HALT clears error and refetches 0.
    clear_mem();
    mem[0] = 32'hA000_0000;
    apply_reset();
    do_start();
    tick();
    tick();
    check("illegal_no_wr", 64'(reg_wr_en), 64'd0);
    tick();
    check("illegal_error", 64'(error), 64'd1);
    check("illegal_not_halted", 64'(halted), 64'd0);
    repeat (3) tick();
    check("illegal_parked", 64'(instr_rd_en), 64'd0);
    do_start();
    check("restart_error_clr", 64'(error), 64'd0);
    check("restart_rd_en", 64'(instr_rd_en), 64'd1);
    check("restart_addr", 64'(instr_addr), 64'd0);

    // Spurious cmd_done in FETCH and coincident with the pulse are both ignored.
    clear_mem();
    mem[0] = 32'h5000_0000;
    mem[1] = HALT_I;
    apply_reset();
    cmd_rdy = 1'b1;
    do_start();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    tick();
    tick();
    cmd_done = 1'b1;
    #1;
    check("rdn_pulse", 64'({begin_rdn_load, begin_dnn_load, begin_proc}), 64'b100);
    tick();
    cmd_done = 1'b0;
    check("rdn_pulse_once", 64'(begin_rdn_load), 64'd0);
    check("rdn_waiting", 64'(instr_rd_en), 64'd0);
    do_start();
    repeat (3) tick();
    check("rdn_still_waiting", 64'(instr_rd_en), 64'd0);
    check("rdn_pc_held", 64'(instr_addr), 64'd0);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check("rdn_next_rd_en", 64'(instr_rd_en), 64'd1);
    check("rdn_next_addr", 64'(instr_addr), 64'd1);

    // Reset while waiting on a LOAD_DNN issued from address 1.
    clear_mem();
    mem[1] = 32'h6000_0000;
    apply_reset();
    cmd_rdy = 1'b1;
    do_start();
    repeat (6) tick();
    check("dnn_pc_at_1", 64'(instr_addr), 64'd1);
    check("dnn_pulse", 64'(begin_dnn_load), 64'd1);
    tick();
    check("dnn_in_wait", 64'(begin_dnn_load), 64'd0);
    rst_n = 1'b0;
    #1;
    check("reset_in_wait_outputs", all_outs(), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cmd_done = (c == 1);
      tick();
      check("post_reset_idle", 64'(instr_rd_en), 64'd0);
    end
    cmd_done = 1'b0;
    do_start();
    check("post_reset_rd_en", 64'(instr_rd_en), 64'd1);
    check("post_reset_addr", 64'(instr_addr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
